// File: rtl/posit_add_pkg.sv
// Shared widths, stage-register layouts and scale helper for the pipelined posit adder.
// POSIT_ADD_STICKY_EN widens the datapath with guard bits and a sticky LSB.
package posit_add_pkg;

  localparam int N   = 8;
  localparam int ES  = 3;
  localparam int RS  = $clog2(N);
  localparam int MW  = N - ES + 3;
  localparam int SW  = ES + RS + 2;
  localparam int SXW = SW + 1;
  localparam int GW  = 2;
  localparam int RGW = RS + 2;
  localparam int SHW = $clog2(MW + 3);

`ifdef POSIT_ADD_STICKY_EN
  localparam int XW = MW + GW + 1;
`else
  localparam int XW = MW;
`endif

  localparam int LZW = $clog2(XW + 1);

  typedef struct packed {
    logic          sign;
    logic          op_sub;
    logic [SW-1:0] lscale;
    logic [SW-1:0] diff;
    logic [MW-1:0] lm;
    logic [MW-1:0] sm;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] lscale;
    logic [XW:0]   sum;
  } s2_t;

  // Combined scale regime*2^ES + exp, sign-extended to SW bits.
  function automatic logic [SW-1:0] to_scale(input logic [RS:0] regime, input logic [ES-1:0] exp);
    return {regime[RS], regime, exp};
  endfunction

endpackage

// File: rtl/posit_add_pipe_if.sv
// Operand/result stream between posit decoder, adder core and encoder.
// The slave modport is the adder side; master is the producer/consumer side.
interface posit_add_pipe_if;
  import posit_add_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic           a_sign, b_sign;
  logic [RS:0]    a_regime, b_regime;
  logic [ES-1:0]  a_exp, b_exp;
  logic [MW-1:0]  a_mant, b_mant;
  logic [N-2:0]   a_mag, b_mag;
  logic           a_zero, b_zero;

  logic           out_valid;
  logic           out_ready;
  logic           out_sign;
  logic [RGW-1:0] out_regime;
  logic [ES-1:0]  out_exp;
  logic [MW-1:0]  out_mant;
  logic           out_zero;
  logic           out_sticky;

  modport slave (
    input  in_valid, a_sign, b_sign, a_regime, b_regime, a_exp, b_exp,
           a_mant, b_mant, a_mag, b_mag, a_zero, b_zero, out_ready,
    output in_ready, out_valid, out_sign, out_regime, out_exp, out_mant,
           out_zero, out_sticky
  );

  modport master (
    output in_valid, a_sign, b_sign, a_regime, b_regime, a_exp, b_exp,
           a_mant, b_mant, a_mag, b_mag, a_zero, b_zero, out_ready,
    input  in_ready, out_valid, out_sign, out_regime, out_exp, out_mant,
           out_zero, out_sticky
  );

endinterface

// File: rtl/posit_lod.sv
// Leading-one detector: counts leading zeros of vec_i and flags an all-zero vector.
module posit_lod #(
  parameter int W   = 8,
  parameter int LZW = $clog2(W + 1)
) (
  input  logic [W-1:0]   vec_i,
  output logic [LZW-1:0] lz_o,
  output logic           zero_o
);

  // Scan upward so the highest set bit is the last one to write lz_o.
  always_comb begin
    lz_o = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) lz_o = LZW'(W - 1 - i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/posit_add_pipe.sv
// 3-stage posit adder core: S1 compare/swap, S2 align+add/sub, S3 normalise+regime/exp split.
// Define POSIT_ADD_STICKY_EN to keep guard bits and report out_sticky.
module posit_add_pipe
  import posit_add_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  posit_add_pipe_if.slave bus
);

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic ld1, ld2, ld3;

  assign ld3 = !s3_valid_q || bus.out_ready;
  assign ld2 = !s2_valid_q || ld3;
  assign ld1 = !s1_valid_q || ld2;
  assign bus.in_ready = ld1;

  // ---------------- S1: compare / swap ----------------
  s1_t s1_d, s1_q;
  logic            use_a, both_zero;
  logic [SW-1:0]   a_scale, b_scale, l_scale, s_scale;
  logic signed [SW:0] scale_diff;

  assign a_scale    = to_scale(bus.a_regime, bus.a_exp);
  assign b_scale    = to_scale(bus.b_regime, bus.b_exp);
  assign both_zero  = bus.a_zero && bus.b_zero;
  assign use_a      = bus.b_zero || (!bus.a_zero && (bus.a_mag >= bus.b_mag));
  assign l_scale    = use_a ? a_scale : b_scale;
  assign s_scale    = use_a ? b_scale : a_scale;
  assign scale_diff = $signed({l_scale[SW-1], l_scale}) - $signed({s_scale[SW-1], s_scale});

  always_comb begin
    s1_d        = '0;
    s1_d.sign   = both_zero ? 1'b0 : (use_a ? bus.a_sign : bus.b_sign);
    s1_d.op_sub = bus.a_sign ^ bus.b_sign;
    s1_d.lscale = l_scale;
    s1_d.lm     = both_zero ? '0 : (use_a ? bus.a_mant : bus.b_mant);
    // A zero small operand leaves sm=0, so the larger passes through untouched.
    if (!(bus.a_zero || bus.b_zero)) begin
      s1_d.sm   = use_a ? bus.b_mant : bus.a_mant;
      s1_d.diff = scale_diff[SW] ? '0 : scale_diff[SW-1:0];
    end
  end

  // ---------------- S2: align + add/sub ----------------
  s2_t s2_d, s2_q;
  logic [SHW-1:0] shamt;
  logic [XW-1:0]  lm_x, sm_x;
  logic [XW:0]    sum;

  assign shamt = (s1_q.diff > SW'(MW + 2)) ? SHW'(MW + 2) : s1_q.diff[SHW-1:0];

`ifdef POSIT_ADD_STICKY_EN
  localparam int WW = MW + GW;
  logic [WW-1:0] sm_wide, sm_shift, sm_lost;

  always_comb begin
    sm_wide  = {s1_q.sm, {GW{1'b0}}};
    sm_shift = sm_wide >> shamt;
    sm_lost  = sm_wide << (WW - int'(shamt));
    sm_x     = {sm_shift, |sm_lost};
    lm_x     = {s1_q.lm, {(GW + 1){1'b0}}};
  end
`else
  always_comb begin
    sm_x = s1_q.sm >> shamt;
    lm_x = s1_q.lm;
  end
`endif

  assign sum = s1_q.op_sub ? ({1'b0, lm_x} - {1'b0, sm_x}) : ({1'b0, lm_x} + {1'b0, sm_x});

  always_comb begin
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.lscale = s1_q.lscale;
    s2_d.sum    = sum;
  end

  // ---------------- S3: LOD + normalise + split ----------------
  logic [LZW-1:0] lz;
  logic           low_zero;
  logic [XW-1:0]  norm;
  logic [SXW-1:0] lsx, scale_d;
  logic           sign_d, zero_d;
  logic [RGW-1:0] regime_d;
  logic [ES-1:0]  exp_d;
  logic [MW-1:0]  mant_d;
  logic           sign_q, zero_q;
  logic [RGW-1:0] regime_q;
  logic [ES-1:0]  exp_q;
  logic [MW-1:0]  mant_q;

  posit_lod #(.W(XW), .LZW(LZW)) u_lod (
    .vec_i  (s2_q.sum[XW-1:0]),
    .lz_o   (lz),
    .zero_o (low_zero)
  );

  assign lsx = {s2_q.lscale[SW-1], s2_q.lscale};

`ifdef POSIT_ADD_STICKY_EN
  logic sticky_d, sticky_q;
`endif

  always_comb begin
    norm     = s2_q.sum[XW-1:0] << lz;
    scale_d  = '0;
    sign_d   = 1'b0;
    zero_d   = 1'b0;
    regime_d = '0;
    exp_d    = '0;
    mant_d   = '0;
`ifdef POSIT_ADD_STICKY_EN
    sticky_d = 1'b0;
`endif
    if (s2_q.sum[XW]) begin
      mant_d  = s2_q.sum[XW -: MW];
      scale_d = lsx + SXW'(1);
`ifdef POSIT_ADD_STICKY_EN
      sticky_d = |s2_q.sum[XW-MW:0];
`endif
    end else if (low_zero) begin
      zero_d = 1'b1;
    end else begin
      mant_d  = norm[XW-1 -: MW];
      scale_d = lsx - SXW'(lz);
`ifdef POSIT_ADD_STICKY_EN
      sticky_d = |norm[XW-MW-1:0];
`endif
    end
    if (!zero_d) begin
      sign_d   = s2_q.sign;
      regime_d = RGW'($signed(scale_d) >>> ES);
      exp_d    = scale_d[ES-1:0];
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      regime_q   <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
`ifdef POSIT_ADD_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      if (ld1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (ld2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_q <= s2_d;
      end
      if (ld3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          sign_q   <= sign_d;
          zero_q   <= zero_d;
          regime_q <= regime_d;
          exp_q    <= exp_d;
          mant_q   <= mant_d;
`ifdef POSIT_ADD_STICKY_EN
          sticky_q <= sticky_d;
`endif
        end
      end
    end
  end

  assign bus.out_valid  = s3_valid_q;
  assign bus.out_sign   = sign_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_regime = regime_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_mant   = mant_q;
`ifdef POSIT_ADD_STICKY_EN
  assign bus.out_sticky = sticky_q;
`else
  assign bus.out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_posit_add_pipe.sv
// Self-checking bench for posit_add_pipe: vector table with latency checks, streaming,
// stall and reset sequences, all results checked through an expected-result queue.
module tb_posit_add_pipe;
  import posit_add_pkg::*;

  typedef struct packed {
    logic          sign;
    logic [RS:0]   regime;
    logic [ES-1:0] exp;
    logic [MW-1:0] mant;
    logic [N-2:0]  mag;
    logic          zero;
  } op_t;

  typedef struct packed {
    logic          sign;
    logic [RS+1:0] regime;
    logic [ES-1:0] exp;
    logic [MW-1:0] mant;
    logic          zero;
    logic          sticky;
  } res_t;

  typedef struct {
    op_t  a;
    op_t  b;
    res_t r;
  } vec_t;

`ifdef POSIT_ADD_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  localparam int NV = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_add_pipe_if bus();

  posit_add_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  int   or_mode = 0;
  int   tcnt = 0;
  res_t expq[$];
  res_t cur_exp;
  vec_t vecs[NV];

  function automatic op_t op(logic s, logic [RS:0] r, logic [ES-1:0] e, logic [MW-1:0] m,
                             logic [N-2:0] mag, logic z);
    op_t x;
    x.sign = s; x.regime = r; x.exp = e; x.mant = m; x.mag = mag; x.zero = z;
    return x;
  endfunction

  function automatic res_t res(logic s, logic [RS+1:0] r, logic [ES-1:0] e, logic [MW-1:0] m,
                               logic z, logic st);
    res_t x;
    x.sign = s; x.regime = r; x.exp = e; x.mant = m; x.zero = z; x.sticky = st;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // out_ready: 0 = held high, 1 = held low, 2 = toggle every 2 cycles
  always begin
    @(posedge clk);
    #1;
    case (or_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'b0;
      default: begin
        tcnt++;
        if (tcnt >= 2) begin
          tcnt = 0;
          bus.out_ready = ~bus.out_ready;
        end
      end
    endcase
  end

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    res_t e;
    if (reset === 1'b1) begin
      expq.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_out++;
        $display("out %0d: sign=%0d regime=%0d exp=%0d mant=%02h zero=%0d sticky=%0d", n_out,
                 bus.out_sign, $signed(bus.out_regime), bus.out_exp, bus.out_mant, bus.out_zero,
                 bus.out_sticky);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=result required=none");
        end else begin
          e = expq.pop_front();
          chk("out_sign", bus.out_sign, e.sign);
          chk("out_regime", bus.out_regime, e.regime);
          chk("out_exp", bus.out_exp, e.exp);
          chk("out_mant", bus.out_mant, e.mant);
          chk("out_zero", bus.out_zero, e.zero);
          chk("out_sticky", bus.out_sticky, e.sticky);
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) expq.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    bus.a_sign = v.a.sign; bus.a_regime = v.a.regime; bus.a_exp = v.a.exp;
    bus.a_mant = v.a.mant; bus.a_mag = v.a.mag; bus.a_zero = v.a.zero;
    bus.b_sign = v.b.sign; bus.b_regime = v.b.regime; bus.b_exp = v.b.exp;
    bus.b_mant = v.b.mant; bus.b_mag = v.b.mag; bus.b_zero = v.b.zero;
    cur_exp = v.r;
  endtask

  task automatic send(input vec_t v);
    logic ok;
    int   g;
    drive(v);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    g = 0;
    while (!ok && g < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!ok) chk("send_accept", ok, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((expq.size() != 0 || bus.out_valid === 1'b1) && g < 60) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t one, none, half, tq_n, big, tiny, zro, s7, b10;
    int  lat, k, n0;

    one  = op(1'b0, 4'h0, 3'd0, 8'h80, 7'h40, 1'b0);
    none = op(1'b1, 4'h0, 3'd0, 8'h80, 7'h40, 1'b0);
    half = op(1'b0, 4'hF, 3'd7, 8'h80, 7'h3C, 1'b0);
    tq_n = op(1'b1, 4'hF, 3'd7, 8'hC0, 7'h3E, 1'b0);
    big  = op(1'b0, 4'h3, 3'd0, 8'h81, 7'h7C, 1'b0);
    tiny = op(1'b0, 4'hD, 3'd0, 8'h81, 7'h02, 1'b0);
    zro  = op(1'b0, 4'h0, 3'd0, 8'h00, 7'h00, 1'b1);
    s7   = op(1'b0, 4'h0, 3'd7, 8'h80, 7'h5C, 1'b0);
    b10  = op(1'b1, 4'h1, 3'd2, 8'hA0, 7'h62, 1'b0);

    vecs[0]  = '{a: one,  b: one,  r: res(1'b0, 5'h00, 3'd1, 8'h80, 1'b0, 1'b0)};
    vecs[1]  = '{a: one,  b: none, r: res(1'b0, 5'h00, 3'd0, 8'h00, 1'b1, 1'b0)};
    vecs[2]  = '{a: one,  b: half, r: res(1'b0, 5'h00, 3'd0, 8'hC0, 1'b0, 1'b0)};
    vecs[3]  = '{a: one,  b: tq_n, r: res(1'b0, 5'h1F, 3'd6, 8'h80, 1'b0, 1'b0)};
    vecs[4]  = '{a: big,  b: tiny, r: res(1'b0, 5'h03, 3'd0, 8'h81, 1'b0, STK)};
    vecs[5]  = '{a: zro,  b: b10,  r: res(1'b1, 5'h01, 3'd2, 8'hA0, 1'b0, 1'b0)};
    vecs[6]  = '{a: zro,  b: zro,  r: res(1'b0, 5'h00, 3'd0, 8'h00, 1'b1, 1'b0)};
    vecs[7]  = '{a: half, b: none, r: res(1'b1, 5'h1F, 3'd7, 8'h80, 1'b0, 1'b0)};
    vecs[8]  = '{a: s7,   b: s7,   r: res(1'b0, 5'h01, 3'd0, 8'h80, 1'b0, 1'b0)};
    vecs[9]  = '{a: half, b: zro,  r: res(1'b0, 5'h1F, 3'd7, 8'h80, 1'b0, 1'b0)};
    vecs[10] = '{a: half, b: half, r: res(1'b0, 5'h00, 3'd0, 8'h80, 1'b0, 1'b0)};
    vecs[11] = '{a: half, b: one,  r: res(1'b0, 5'h00, 3'd0, 8'hC0, 1'b0, 1'b0)};

    // Reset state
    reset = 1'b1;
    bus.in_valid = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_zero", bus.out_zero, 0);
    chk("rst_out_mant", bus.out_mant, 0);
    chk("rst_out_regime", bus.out_regime, 0);
    chk("rst_out_sticky", bus.out_sticky, 0);
    @(posedge clk);
    #1;

    // Table: one pair at a time, checking 3-cycle latency
    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("latency_%0d", i), lat, 3);
      @(posedge clk);
      #1;
    end
    drain();

    // Streaming: 8 back-to-back pairs, out_ready toggling every 2 cycles
    n0 = n_out;
    or_mode = 2;
    for (int i = 0; i < 8; i++) send(vecs[i]);
    drain();
    chk("stream_count", n_out - n0, 8);
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Full stall: only 3 pairs accepted, held output stable
    or_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(vecs[k]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("stall_accepts", k, 3);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_mant", bus.out_mant, vecs[0].r.mant);
      chk("stall_exp", bus.out_exp, vecs[0].r.exp);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    n0 = n_out;
    or_mode = 0;
    drain();
    chk("stall_drained", n_out - n0, 3);

    // Reset with 2 pairs in flight
    repeat (2) @(posedge clk);
    #1;
    send(vecs[2]);
    send(vecs[3]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_mant", bus.out_mant, 0);
    n0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_discard", n_out - n0, 0);
    chk("midrst_queue", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
